// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Purpose
//   Shares one external ALU between two requesters. An accepted operation is
//   registered onto the ALU inputs, the ALU is enabled for exactly one cycle,
//   and its result and flags are captured and returned to the requester that
//   issued the operation. A program status register (psr) tracks the flags of
//   every completed operation except memory/jump (class 4'b0100) and branch
//   (class 4'b1100) operations.
//
//   Sequence: IDLE (accept) -> DRIVE (ALU enabled) -> RESP (response pulse)
//   -> IDLE. Accept in cycle T gives a response in cycle T+2; the next
//   accept can happen in cycle T+3 at the earliest.
//
// Configuration
//   ALU_ARBITER_RR_EN  defined   : round-robin tie-break; when both requesters
//                                  are valid, the one not granted last wins.
//                      undefined : fixed priority; requester 0 wins every tie.
//
// Ports
//   clk, reset                 clock; synchronous active-low reset
//   req{0,1}_valid/_ready      request handshake per requester
//   req{0,1}_op/_src/_dst      operation control word and operands
//   rsp{0,1}_valid             one-cycle response pulse per requester
//   rsp_result, rsp_flags      captured ALU result and {c, low, ovf, z, n}
//   psr                        program status register, rsp_flags bit order
//   alu_enable/_src/_dst/_op   drive the external ALU
//   alu_result, alu_carry, alu_low, alu_overflow, alu_zero, alu_negative
//                              outputs of the external ALU
//   dbg_state                  current FSM state (IDLE=0, DRIVE=1, RESP=2)
//
// Handshake: a request transfers in a cycle where reqN_valid and reqN_ready
// are both high. reqN_ready is combinational, only ever high in IDLE, and at
// most one ready is high per cycle. A requester keeps valid and its payload
// stable until it sees ready; a valid dropped before ready is simply ignored.
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH   = 16,
  parameter int CTL_LEN = 8
) (
  input  logic               clk,
  input  logic               reset,

  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [CTL_LEN-1:0] req0_op,
  input  logic [WIDTH-1:0]   req0_src,
  input  logic [WIDTH-1:0]   req0_dst,

  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [CTL_LEN-1:0] req1_op,
  input  logic [WIDTH-1:0]   req1_src,
  input  logic [WIDTH-1:0]   req1_dst,

  output logic               rsp0_valid,
  output logic               rsp1_valid,
  output logic [WIDTH-1:0]   rsp_result,
  output logic [4:0]         rsp_flags,
  output logic [4:0]         psr,

  output logic               alu_enable,
  output logic [WIDTH-1:0]   alu_src,
  output logic [WIDTH-1:0]   alu_dst,
  output logic [CTL_LEN-1:0] alu_op,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_carry,
  input  logic               alu_low,
  input  logic               alu_overflow,
  input  logic               alu_zero,
  input  logic               alu_negative,

  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic               r_grantee;     // requester index of the operation in flight
  logic [CTL_LEN-1:0] r_alu_op;
  logic [WIDTH-1:0]   r_alu_src;
  logic [WIDTH-1:0]   r_alu_dst;
  logic [WIDTH-1:0]   r_rsp_result;
  logic [4:0]         r_rsp_flags;
  logic [4:0]         r_psr;

`ifdef ALU_ARBITER_RR_EN
  logic               r_last_grant;  // index of the most recently accepted requester
`endif

  logic               w_accept;
  logic               w_pick1;       // 1 when requester 1 wins the current arbitration
  logic [4:0]         w_alu_flags;
  logic               w_psr_hold;

  assign w_alu_flags = {alu_carry, alu_low, alu_overflow, alu_zero, alu_negative};

  // Memory/jump and branch classes complete normally but must not disturb psr.
  assign w_psr_hold = (r_alu_op[7:4] == 4'b0100) || (r_alu_op[7:4] == 4'b1100);

  // Arbitration: a lone valid requester always wins; a tie goes to requester 0
  // under fixed priority, or to the requester not granted last under round-robin.
  always_comb begin
    w_pick1 = 1'b0;
`ifdef ALU_ARBITER_RR_EN
    w_pick1 = req1_valid && (!req0_valid || !r_last_grant);
`else
    w_pick1 = req1_valid && !req0_valid;
`endif
  end

  // Next-state and output decode.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    alu_enable   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          w_accept     = 1'b1;
          req0_ready   = !w_pick1;
          req1_ready   = w_pick1;
          w_next_state = S_DRIVE;
        end
      end
      S_DRIVE: begin
        alu_enable   = 1'b1;
        w_next_state = S_RESP;
      end
      S_RESP: begin
        rsp0_valid   = !r_grantee;
        rsp1_valid   = r_grantee;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register plus datapath registers. Reset discards any operation in
  // flight: the capture below only runs outside reset, so neither the
  // response registers nor psr see an operation interrupted by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_grantee    <= 1'b0;
      r_alu_op     <= '0;
      r_alu_src    <= '0;
      r_alu_dst    <= '0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
      r_psr        <= '0;
`ifdef ALU_ARBITER_RR_EN
      r_last_grant <= 1'b1;
`endif
    end else begin
      r_state <= w_next_state;

      if (w_accept) begin
        r_grantee <= w_pick1;
        r_alu_op  <= w_pick1 ? req1_op  : req0_op;
        r_alu_src <= w_pick1 ? req1_src : req0_src;
        r_alu_dst <= w_pick1 ? req1_dst : req0_dst;
`ifdef ALU_ARBITER_RR_EN
        r_last_grant <= w_pick1;
`endif
      end

      // End of DRIVE: the ALU has seen stable inputs for the whole cycle.
      if (r_state == S_DRIVE) begin
        r_rsp_result <= alu_result;
        r_rsp_flags  <= w_alu_flags;
        if (!w_psr_hold) begin
          r_psr <= w_alu_flags;
        end
      end
    end
  end

  assign alu_op     = r_alu_op;
  assign alu_src    = r_alu_src;
  assign alu_dst    = r_alu_dst;
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;
  assign psr        = r_psr;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int WIDTH   = 16;
  localparam int CTL_LEN = 8;

`ifdef ALU_ARBITER_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  // ---------------------------------------------------------------- signals
  logic               clk = 1'b0;
  logic               reset;
  logic               req0_valid, req1_valid;
  logic               req0_ready, req1_ready;
  logic [CTL_LEN-1:0] req0_op, req1_op;
  logic [WIDTH-1:0]   req0_src, req0_dst, req1_src, req1_dst;
  logic               rsp0_valid, rsp1_valid;
  logic [WIDTH-1:0]   rsp_result;
  logic [4:0]         rsp_flags;
  logic [4:0]         psr;
  logic               alu_enable;
  logic [WIDTH-1:0]   alu_src, alu_dst;
  logic [CTL_LEN-1:0] alu_op;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_carry, alu_low, alu_overflow, alu_zero, alu_negative;
  logic [1:0]         dbg_state;

  alu_arbiter #(.WIDTH(WIDTH), .CTL_LEN(CTL_LEN)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_op      (req0_op),
    .req0_src     (req0_src),
    .req0_dst     (req0_dst),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_op      (req1_op),
    .req1_src     (req1_src),
    .req1_dst     (req1_dst),
    .rsp0_valid   (rsp0_valid),
    .rsp1_valid   (rsp1_valid),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .psr          (psr),
    .alu_enable   (alu_enable),
    .alu_src      (alu_src),
    .alu_dst      (alu_dst),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_low      (alu_low),
    .alu_overflow (alu_overflow),
    .alu_zero     (alu_zero),
    .alu_negative (alu_negative),
    .dbg_state    (dbg_state)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- ALU model
  // Returns {result[15:0], carry, low, overflow, zero, negative}.
  // Sub-op 5 adds, sub-op B compares (dst - src), anything else XORs.
  function automatic logic [20:0] alu_fn(input logic [7:0] op,
                                         input logic [15:0] src,
                                         input logic [15:0] dst);
    logic [16:0] sum;
    logic [15:0] res;
    logic        c, l, o;
    c = 1'b0; l = 1'b0; o = 1'b0;
    case (op[3:0])
      4'h5: begin
        sum = {1'b0, src} + {1'b0, dst};
        res = sum[15:0];
        c   = sum[16];
        o   = (src[15] == dst[15]) && (res[15] != src[15]);
      end
      4'hB: begin
        res = dst - src;
        l   = (dst < src);
      end
      default: res = src ^ dst;
    endcase
    return {res, c, l, o, (res == 16'h0000), res[15]};
  endfunction

  always_comb
    {alu_result, alu_carry, alu_low, alu_overflow, alu_zero, alu_negative} =
      alu_fn(alu_op, alu_src, alu_dst);

  // ---------------------------------------------------------------- scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_acc;
  bit m_last_grant;
  bit m_acc0, m_acc1;
  bit rand_mode = 1'b0;
  logic [4:0]  m_psr, m_flags;
  logic [15:0] m_res;
  logic [39:0] m_drv;
  // entry: {due[31:0], who, psr_keep, result[15:0], flags[4:0]}
  logic [54:0] exp_q[$];

  task automatic model_reset();
    last_acc     = cyc - 100;
    m_last_grant = 1'b1;
    m_psr        = 5'b0;
    m_flags      = 5'b0;
    m_res        = 16'h0;
    m_acc0       = 1'b0;
    m_acc1       = 1'b0;
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic gen_req(output logic v, output logic [7:0] op,
                         output logic [15:0] s, output logic [15:0] d);
    logic [3:0] cls, sub;
    v = ($urandom_range(0, 3) != 0);
    case ($urandom_range(0, 3))
      0:       cls = 4'h0;
      1:       cls = 4'h4;
      2:       cls = 4'hC;
      default: cls = 4'($urandom_range(0, 15));
    endcase
    case ($urandom_range(0, 2))
      0:       sub = 4'h5;
      1:       sub = 4'hB;
      default: sub = 4'($urandom_range(0, 15));
    endcase
    op = {cls, sub};
    s  = 16'($urandom);
    d  = ($urandom_range(0, 3) == 0) ? s : 16'($urandom);
  endtask

  // Per-cycle model check, sampled on the falling edge.
  task automatic check_cycle();
    bit          pick1, acc;
    bit          drive_cyc;
    logic [1:0]  exp_rsp, exp_rdy;
    logic [54:0] e;
    logic [20:0] a;
    logic [7:0]  op;
    logic [15:0] s, d;
    @(negedge clk);
    drive_cyc = (cyc == last_acc + 1);

    n_tests++;
    if (alu_enable !== drive_cyc) begin
      n_fail++;
      $display("FAIL alu_enable cyc=%0d got=%b want=%b", cyc, alu_enable, drive_cyc);
    end
    if (drive_cyc) begin
      n_tests++;
      if ({alu_op, alu_src, alu_dst} !== m_drv) begin
        n_fail++;
        $display("FAIL alu_inputs cyc=%0d got=%h want=%h", cyc, {alu_op, alu_src, alu_dst}, m_drv);
      end
    end

    exp_rsp = 2'b00;
    if (exp_q.size() > 0 && exp_q[0][54:23] == 32'(cyc)) begin
      e       = exp_q.pop_front();
      exp_rsp = e[22] ? 2'b10 : 2'b01;
      m_res   = e[20:5];
      m_flags = e[4:0];
      if (!e[21]) m_psr = e[4:0];
    end
    n_tests++;
    if ({rsp1_valid, rsp0_valid} !== exp_rsp) begin
      n_fail++;
      $display("FAIL rsp_valid cyc=%0d got=%b want=%b", cyc, {rsp1_valid, rsp0_valid}, exp_rsp);
    end
    n_tests++;
    if (rsp_result !== m_res) begin
      n_fail++;
      $display("FAIL rsp_result cyc=%0d got=%h want=%h", cyc, rsp_result, m_res);
    end
    n_tests++;
    if (rsp_flags !== m_flags) begin
      n_fail++;
      $display("FAIL rsp_flags cyc=%0d got=%b want=%b", cyc, rsp_flags, m_flags);
    end
    n_tests++;
    if (psr !== m_psr) begin
      n_fail++;
      $display("FAIL psr cyc=%0d got=%b want=%b", cyc, psr, m_psr);
    end

    // Free once three cycles have passed since the previous accept.
    acc   = ((cyc - last_acc) >= 3) && (req0_valid || req1_valid);
    pick1 = 1'b0;
    if (acc) begin
      if (req0_valid && req1_valid) pick1 = RR_MODE ? !m_last_grant : 1'b0;
      else                          pick1 = req1_valid;
    end
    exp_rdy = acc ? (pick1 ? 2'b10 : 2'b01) : 2'b00;
    n_tests++;
    if ({req1_ready, req0_ready} !== exp_rdy) begin
      n_fail++;
      $display("FAIL ready cyc=%0d got=%b want=%b", cyc, {req1_ready, req0_ready}, exp_rdy);
    end

    m_acc0 = acc && !pick1;
    m_acc1 = acc && pick1;
    if (acc) begin
      op = pick1 ? req1_op  : req0_op;
      s  = pick1 ? req1_src : req0_src;
      d  = pick1 ? req1_dst : req0_dst;
      a  = alu_fn(op, s, d);
      exp_q.push_back({32'(cyc + 2), pick1, (op[7:4] == 4'h4 || op[7:4] == 4'hC), a});
      last_acc     = cyc;
      m_last_grant = pick1;
      m_drv        = {op, s, d};
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
    if (rand_mode) begin
      if (m_acc0 || !req0_valid) gen_req(req0_valid, req0_op, req0_src, req0_dst);
      else if ($urandom_range(0, 7) == 0) req0_valid = 1'b0;
      if (m_acc1 || !req1_valid) gen_req(req1_valid, req1_op, req1_src, req1_dst);
      else if ($urandom_range(0, 7) == 0) req1_valid = 1'b0;
    end else begin
      if (m_acc0) req0_valid = 1'b0;
      if (m_acc1) req1_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset      = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_tests++;
    if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
    n_tests++;
    if (alu_enable !== 1'b0) begin n_fail++; $display("FAIL reset_alu_enable got=%b want=0", alu_enable); end
    n_tests++;
    if ({rsp1_valid, rsp0_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got=%b want=00", {rsp1_valid, rsp0_valid}); end
    n_tests++;
    if (rsp_result !== 16'h0) begin n_fail++; $display("FAIL reset_rsp_result got=%h want=0", rsp_result); end
    n_tests++;
    if (rsp_flags !== 5'b0) begin n_fail++; $display("FAIL reset_rsp_flags got=%b want=0", rsp_flags); end
    n_tests++;
    if (psr !== 5'b0) begin n_fail++; $display("FAIL reset_psr got=%b want=0", psr); end
    n_tests++;
    if ({alu_op, alu_src, alu_dst} !== 40'h0) begin n_fail++; $display("FAIL reset_alu_inputs got=%h want=0", {alu_op, alu_src, alu_dst}); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_add();
    req0_op = 8'h05; req0_src = 16'h0003; req0_dst = 16'h0004; req0_valid = 1'b1;
    check_cycle();
    n_tests++;
    if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready got=%b want=1", req0_ready); end
    advance(); check_cycle();
    n_tests++;
    if ({alu_enable, alu_op} !== {1'b1, 8'h05}) begin n_fail++; $display("FAIL add_drive got=%h want=105", {alu_enable, alu_op}); end
    advance(); check_cycle();
    n_tests++;
    if ({rsp1_valid, rsp0_valid, rsp_result, rsp_flags} !== {2'b01, 16'h0007, 5'b00000}) begin
      n_fail++;
      $display("FAIL add_rsp got=%b/%h/%b want=01/0007/00000", {rsp1_valid, rsp0_valid}, rsp_result, rsp_flags);
    end
    advance(); check_cycle();
    n_tests++;
    if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL add_pulse_width got=%b want=0", rsp0_valid); end
    advance();
  endtask

  task automatic test_compare_zero();
    req0_op = 8'h0B; req0_src = 16'h0005; req0_dst = 16'h0005; req0_valid = 1'b1;
    check_cycle(); advance();
    check_cycle(); advance();
    check_cycle();
    n_tests++;
    if ({rsp_flags[3], rsp_flags[1], rsp_flags[0]} !== 3'b010) begin
      n_fail++;
      $display("FAIL cmp_flags got low/zero/neg=%b want=010", {rsp_flags[3], rsp_flags[1], rsp_flags[0]});
    end
    n_tests++;
    if (psr !== 5'b00010) begin n_fail++; $display("FAIL cmp_psr got=%b want=00010", psr); end
    advance();
  endtask

  task automatic test_psr_hold();
    req0_op = 8'h40; req0_src = 16'h1234; req0_dst = 16'h0000; req0_valid = 1'b1;
    check_cycle(); advance();
    check_cycle(); advance();
    check_cycle();
    n_tests++;
    if (psr !== 5'b00010) begin n_fail++; $display("FAIL load_psr got=%b want=00010", psr); end
    n_tests++;
    if ({rsp0_valid, rsp_result, rsp_flags} !== {1'b1, 16'h1234, 5'b00000}) begin
      n_fail++;
      $display("FAIL load_rsp got=%b/%h/%b want=1/1234/00000", rsp0_valid, rsp_result, rsp_flags);
    end
    advance();
  endtask

  task automatic test_reset_in_drive();
    req0_op = 8'h05; req0_src = 16'h0001; req0_dst = 16'h0001; req0_valid = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL rid_ready got=%b want=1", req0_ready); end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    reset      = 1'b0;
    @(negedge clk);
    n_tests++;
    if (alu_enable !== 1'b1) begin n_fail++; $display("FAIL rid_in_drive got=%b want=1", alu_enable); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({dbg_state, alu_enable, rsp1_valid, rsp0_valid} !== 5'b00000) begin
      n_fail++;
      $display("FAIL rid_after got state/en/rsp=%b want=00000", {dbg_state, alu_enable, rsp1_valid, rsp0_valid});
    end
    n_tests++;
    if ({psr, rsp_result} !== 21'h0) begin n_fail++; $display("FAIL rid_regs got psr=%b result=%h want=0/0", psr, rsp_result); end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_tests++;
    if ({rsp1_valid, rsp0_valid, psr} !== 7'b0) begin n_fail++; $display("FAIL rid_no_pulse got=%b want=0", {rsp1_valid, rsp0_valid, psr}); end
    @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic test_tie();
    logic [1:0] exp_rdy, exp_rsp;
    logic [1:0] grant_hist[4];
    reset      = 1'b0;
    req0_op    = 8'h05; req0_src = 16'h0001; req0_dst = 16'h0002; req0_valid = 1'b1;
    req1_op    = 8'h0B; req1_src = 16'h0003; req1_dst = 16'h0004; req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      exp_rdy = 2'b00;
      if (k % 3 == 0) exp_rdy = (RR_MODE && ((k / 3) % 2 == 1)) ? 2'b10 : 2'b01;
      if (k % 3 == 0) grant_hist[k / 3] = exp_rdy;
      exp_rsp = (k % 3 == 2) ? grant_hist[k / 3] : 2'b00;
      n_tests++;
      if ({req1_ready, req0_ready} !== exp_rdy) begin
        n_fail++;
        $display("FAIL tie_ready k=%0d got=%b want=%b", k, {req1_ready, req0_ready}, exp_rdy);
      end
      n_tests++;
      if ({rsp1_valid, rsp0_valid} !== exp_rsp) begin
        n_fail++;
        $display("FAIL tie_rsp k=%0d got=%b want=%b", k, {rsp1_valid, rsp0_valid}, exp_rsp);
      end
      @(posedge clk);
      #1;
    end
    do_reset();
  endtask

  task automatic test_random();
    rand_mode = 1'b1;
    gen_req(req0_valid, req0_op, req0_src, req0_dst);
    gen_req(req1_valid, req1_op, req1_src, req1_dst);
    for (int i = 0; i < 600; i++) begin
      check_cycle();
      advance();
    end
    rand_mode  = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    // Drain any operation still in flight.
    repeat (4) begin
      check_cycle();
      advance();
    end
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    reset      = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op    = '0;   req1_op    = '0;
    req0_src   = '0;   req0_dst   = '0;
    req1_src   = '0;   req1_dst   = '0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_add();
    test_compare_zero();
    test_psr_hold();
    test_reset_in_drive();
    test_tie();
    test_random();
    test_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
